// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: sequencing controller for the four inter-stage buffers of
// the 16-bit core (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves wide 32-bit
// memory accesses, taken branches, load-use hazards and interrupt injection,
// and counts PC-hold cycles in a saturating counter.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_ex_mem_read, i_ex_rdst  load in EX and its destination register
//   i_id_rsrc1/2, i_id_use1/2 source registers of ID and whether they are read
//   i_branch_taken            branch resolved taken in EX
//   i_mem_wide                EX/MEM instruction needs a two-half access
//   i_int                     external interrupt request
//   o_en_*                    buffer load enables
//   o_flush_*                 buffer loads a bubble when enabled
//   o_pc_hold                 PC does not update
//   o_mem_half                0 = low half / first cycle, 1 = high half
//   o_int_inject              IF/ID loads the INT pseudo-instruction
//   o_stall_cnt               saturating count of PC-hold cycles
//
// Control outputs are combinational (Mealy) from state and inputs; the
// buffers act on them at the next rising edge.
module pipe_stage_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned RegAddr = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_ex_mem_read,
    input  logic [RegAddr-1:0] i_ex_rdst,
    input  logic [RegAddr-1:0] i_id_rsrc1,
    input  logic [RegAddr-1:0] i_id_rsrc2,
    input  logic               i_id_use1,
    input  logic               i_id_use2,
    input  logic               i_branch_taken,
    input  logic               i_mem_wide,
    input  logic               i_int,
    output logic               o_en_ifid,
    output logic               o_en_idex,
    output logic               o_en_exmem,
    output logic               o_en_memwb,
    output logic               o_flush_ifid,
    output logic               o_flush_idex,
    output logic               o_flush_memwb,
    output logic               o_pc_hold,
    output logic               o_mem_half,
    output logic               o_int_inject,
    output logic [CNT_W-1:0]   o_stall_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_WIDE2 = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               int_pend;
    logic               int_pend_nxt;
    logic               int_take;
    logic               load_use;
    logic [CNT_W-1:0]   stall_cnt;

    // Load in EX writes a register that the ID instruction actually reads.
    assign load_use = i_ex_mem_read &&
                      ((i_id_use1 && (i_id_rsrc1 == i_ex_rdst)) ||
                       (i_id_use2 && (i_id_rsrc2 == i_ex_rdst)));

    // Next-state and control outputs; priority wide > branch > load-use > int.
    always_comb begin
        state_nxt     = ST_RUN;
        int_take      = 1'b0;
        o_en_ifid     = 1'b1;
        o_en_idex     = 1'b1;
        o_en_exmem    = 1'b1;
        o_en_memwb    = 1'b1;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        o_flush_memwb = 1'b0;
        o_pc_hold     = 1'b0;
        o_mem_half    = 1'b0;
        o_int_inject  = 1'b0;

        if (rst) begin
            // Bubble every buffer; EX/MEM is bubbled by the flushed ID/EX.
            o_flush_ifid  = 1'b1;
            o_flush_idex  = 1'b1;
            o_flush_memwb = 1'b1;
            o_pc_hold     = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (i_mem_wide) begin
                        // First half: freeze front end, bubble into WB.
                        o_en_ifid     = 1'b0;
                        o_en_idex     = 1'b0;
                        o_en_exmem    = 1'b0;
                        o_flush_memwb = 1'b1;
                        o_pc_hold     = 1'b1;
                        state_nxt     = ST_WIDE2;
                    end else if (i_branch_taken) begin
                        o_flush_ifid = 1'b1;
                        o_flush_idex = 1'b1;
                    end else if (load_use) begin
                        o_en_ifid    = 1'b0;
                        o_flush_idex = 1'b1;
                        o_pc_hold    = 1'b1;
                    end else if (int_pend) begin
                        // Hold PC so the interrupted instruction is refetched.
                        o_int_inject = 1'b1;
                        o_pc_hold    = 1'b1;
                        int_take     = 1'b1;
                    end
                end
                ST_WIDE2: begin
                    o_mem_half = 1'b1;
                    if (i_branch_taken) begin
                        o_flush_ifid = 1'b1;
                        o_flush_idex = 1'b1;
                    end else if (load_use) begin
                        o_en_ifid    = 1'b0;
                        o_flush_idex = 1'b1;
                        o_pc_hold    = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // A new request wins over the clear in the same cycle.
    assign int_pend_nxt = i_int | (int_pend & ~int_take);

    // State, pending interrupt and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            int_pend  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            int_pend <= int_pend_nxt;
            if (o_pc_hold && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
module tb_pipe_stage_ctrl;

    logic       clk;
    logic       rst;
    logic       mem_read;
    logic [2:0] rdst;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic       wide;
    logic       irq;

    logic        en_ifid, en_idex, en_exmem, en_memwb;
    logic        fl_ifid, fl_idex, fl_memwb, pc_hold, mem_half, inject;
    logic [15:0] cnt;
    logic        s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb;
    logic        s_fl_ifid, s_fl_idex, s_fl_memwb, s_pc_hold, s_mem_half, s_inject;
    logic [3:0]  s_cnt;

    pipe_stage_ctrl dut (
        .clk(clk), .rst(rst),
        .i_ex_mem_read(mem_read), .i_ex_rdst(rdst),
        .i_id_rsrc1(rs1), .i_id_rsrc2(rs2),
        .i_id_use1(use1), .i_id_use2(use2),
        .i_branch_taken(br), .i_mem_wide(wide), .i_int(irq),
        .o_en_ifid(en_ifid), .o_en_idex(en_idex),
        .o_en_exmem(en_exmem), .o_en_memwb(en_memwb),
        .o_flush_ifid(fl_ifid), .o_flush_idex(fl_idex),
        .o_flush_memwb(fl_memwb), .o_pc_hold(pc_hold),
        .o_mem_half(mem_half), .o_int_inject(inject),
        .o_stall_cnt(cnt)
    );

    pipe_stage_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .i_ex_mem_read(mem_read), .i_ex_rdst(rdst),
        .i_id_rsrc1(rs1), .i_id_rsrc2(rs2),
        .i_id_use1(use1), .i_id_use2(use2),
        .i_branch_taken(br), .i_mem_wide(wide), .i_int(irq),
        .o_en_ifid(s_en_ifid), .o_en_idex(s_en_idex),
        .o_en_exmem(s_en_exmem), .o_en_memwb(s_en_memwb),
        .o_flush_ifid(s_fl_ifid), .o_flush_idex(s_fl_idex),
        .o_flush_memwb(s_fl_memwb), .o_pc_hold(s_pc_hold),
        .o_mem_half(s_mem_half), .o_int_inject(s_inject),
        .o_stall_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl order: en_ifid en_idex en_exmem en_memwb fl_ifid fl_idex fl_memwb pc_hold mem_half inject
    typedef struct {
        logic [9:0]  ctrl;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
        bit          cnt_known;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference state: "second half of a wide access is due", pending
    // interrupt, and the two counters as plain integers.
    bit m_second_half;
    bit m_pend;
    int m_cnt;
    int m_cnt_s;
    bit m_cnt_known;

    task automatic cyc(input bit r, input bit mr, input int rd, input int a1,
                       input int a2, input bit u1, input bit u2, input bit b,
                       input bit w, input bit i);
        exp_t e;
        bit   hz;
        bit   e_if, e_ie, e_em, e_mw, f_if, f_ie, f_mw, hold, half, inj;
        @(posedge clk);
        #1;
        rst = r; mem_read = mr; rdst = 3'(rd); rs1 = 3'(a1); rs2 = 3'(a2);
        use1 = u1; use2 = u2; br = b; wide = w; irq = i;
        cyc_no++;

        {e_if, e_ie, e_em, e_mw} = 4'b1111;
        {f_if, f_ie, f_mw, hold, half, inj} = 6'b0;
        hz = mr && ((u1 && (a1 == rd)) || (u2 && (a2 == rd)));
        if (r) begin
            f_if = 1; f_ie = 1; f_mw = 1; hold = 1;
        end else begin
            half = m_second_half;
            if (!m_second_half && w) begin
                e_if = 0; e_ie = 0; e_em = 0; f_mw = 1; hold = 1;
            end else if (b) begin
                f_if = 1; f_ie = 1;
            end else if (hz) begin
                e_if = 0; f_ie = 1; hold = 1;
            end else if (!m_second_half && m_pend) begin
                inj = 1; hold = 1;
            end
        end
        e.ctrl = {e_if, e_ie, e_em, e_mw, f_if, f_ie, f_mw, hold, half, inj};
        e.cnt = 16'(m_cnt);
        e.cnt_s = 4'(m_cnt_s);
        e.cnt_known = m_cnt_known;
        e.cyc = cyc_no;
        exp_q.push_back(e);

        if (r) begin
            m_second_half = 0; m_pend = 0; m_cnt = 0; m_cnt_s = 0; m_cnt_known = 1;
        end else begin
            m_second_half = !m_second_half && w;
            m_pend = i || (m_pend && !inj);
            if (hold) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 15) m_cnt_s++;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the controller presents a full control word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex,
                     fl_memwb, pc_hold, mem_half, inject} !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl cycle %0d got %b want %b", e.cyc,
                             {en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex,
                              fl_memwb, pc_hold, mem_half, inject}, e.ctrl);
                end
                checks++;
                if ({s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb, s_fl_ifid, s_fl_idex,
                     s_fl_memwb, s_pc_hold, s_mem_half, s_inject} !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl_w4 cycle %0d got %b want %b", e.cyc,
                             {s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb, s_fl_ifid,
                              s_fl_idex, s_fl_memwb, s_pc_hold, s_mem_half, s_inject},
                             e.ctrl);
                end
                if (e.cnt_known) begin
                    checks++;
                    if (cnt !== e.cnt) begin
                        errors++;
                        $display("FAIL stall_cnt cycle %0d got %0d want %0d", e.cyc, cnt, e.cnt);
                    end
                    checks++;
                    if (s_cnt !== e.cnt_s) begin
                        errors++;
                        $display("FAIL stall_cnt_w4 cycle %0d got %0d want %0d", e.cyc, s_cnt, e.cnt_s);
                    end
                end
            end
        end
    end

    initial begin
        bit r, w, b, mr, u1, u2, i;
        int rd;
        rst = 1; mem_read = 0; rdst = 0; rs1 = 0; rs2 = 0;
        use1 = 0; use2 = 0; br = 0; wide = 0; irq = 0;
        m_second_half = 0; m_pend = 0; m_cnt = 0; m_cnt_s = 0; m_cnt_known = 0;

        // Reset for two cycles, then defaults.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Load-use on rsrc2, then the same without use2.
        cyc(0, 1, 3, 0, 3, 0, 1, 0, 0, 0);
        idle();
        cyc(0, 1, 3, 0, 3, 0, 0, 0, 0, 0);
        idle();
        // Wide access for two cycles.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        // Wide with branch; branch re-asserted in WIDE2.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle();
        // Branch and load-use together: branch wins.
        cyc(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);
        idle();
        // Interrupt during a load-use stall, injected the cycle after.
        cyc(0, 1, 2, 2, 0, 1, 0, 0, 0, 1);
        idle();
        idle();
        // Two requests before injection merge into one.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        idle();
        // Request in the same cycle the pending one is taken re-arms it.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        // Reset during WIDE2 aborts the access.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        // Twenty load-use cycles: the 4-bit counter saturates at 15.
        for (int k = 0; k < 20; k++) cyc(0, 1, 4, 0, 4, 0, 1, 0, 0, 0);
        idle();

        // Randomised traffic, small register space so hazards are frequent.
        for (int k = 0; k < 500; k++) begin
            r  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 4) == 0);
            mr = ($urandom_range(0, 2) == 0);
            u1 = $urandom_range(0, 1) == 1;
            u2 = $urandom_range(0, 1) == 1;
            i  = ($urandom_range(0, 7) == 0);
            rd = $urandom_range(0, 3);
            cyc(r, mr, rd, $urandom_range(0, 3), $urandom_range(0, 3), u1, u2, b, w, i);
        end
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Pipeline sequencing controller for the 16-bit core. Drives the enable and flush (bubble) controls of the four inter-stage buffers: IF/ID, ID/EX, EX/MEM (ALU→memory) and MEM/WB. It resolves four conditions that alter pipeline flow:
- load-use hazards;
- taken branches;
- two-cycle 32-bit memory accesses (PC push/pop over the 16-bit data bus);
- external interrupt injection.

It also keeps a saturating stall-cycle counter.

## Interface
Parameters:
- CNT_W, 16, width of the stall counter
- RegAddr, 3, register-address width (matches the buffers' Rdst width)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- i_ex_mem_read  in  1  instruction in EX is a load
- i_ex_rdst  in  RegAddr  destination register of the instruction in EX
- i_id_rsrc1, i_id_rsrc2  in  RegAddr  source registers of the instruction in ID
- i_id_use1, i_id_use2  in  1  ID instruction actually reads rsrc1 / rsrc2
- i_branch_taken  in  1  branch resolved taken in EX this cycle
- i_mem_wide  in  1  instruction held in EX/MEM needs a 32-bit (two-half) memory access
- i_int  in  1  external interrupt request (pulse, ≥1 cycle)
- o_en_ifid, o_en_idex, o_en_exmem, o_en_memwb  out  1 each  buffer load enables
- o_flush_ifid, o_flush_idex, o_flush_memwb  out  1 each  buffer loads zero controls (bubble) when enabled
- o_pc_hold  out  1  PC register does not update
- o_mem_half  out  1  memory half select: 0 = low 16 bits / first cycle, 1 = high / second cycle
- o_int_inject  out  1  IF/ID loads the INT pseudo-instruction instead of fetched data
- o_stall_cnt  out  CNT_W  count of cycles with o_pc_hold=1, saturating

## Operation
- State machine has two states, RUN and WIDE2. Registers: state, int_pend, stall counter.
- Outputs are combinational from state and inputs (Mealy). Buffers act on the next posedge.
- Default in RUN: all enables are 1, all flushes 0, pc_hold 0, mem_half 0, int_inject 0.
- Evaluation in RUN uses the following strict priority; the first match wins.
  1. **Wide access** (i_mem_wide=1):
     - mem_half=0.
     - en_ifid, en_idex and en_exmem are 0, so IF/ID, ID/EX and EX/MEM are frozen.
     - pc_hold=1.
     - en_memwb=1 with flush_memwb=1.
     - Next state is WIDE2.
     - Branch, hazard and interrupt are ignored this cycle. A frozen branch in EX re-asserts i_branch_taken in WIDE2.
  2. **Branch taken**: flush_ifid=1, flush_idex=1. The PC is not held; it loads the target.
  3. **Load-use**: triggers when i_ex_mem_read AND at least one of the following holds:
     - i_id_use1 and i_id_rsrc1==i_ex_rdst;
     - i_id_use2 and i_id_rsrc2==i_ex_rdst.

     Response: en_ifid=0, pc_hold=1, flush_idex=1 (bubble into EX). EX/MEM and MEM/WB advance. Exactly one stall cycle per occurrence.
  4. **Interrupt** (int_pend=1): int_inject=1, flush_ifid=0, pc_hold=1 so the interrupted instruction is refetched. int_pend clears.
- WIDE2 state:
  - mem_half=1 and all enables are 1.
  - Branch and load-use rules 2–3 apply normally; interrupt injection is suppressed.
  - Next state is RUN unconditionally. i_mem_wide is ignored in WIDE2.
- int_pend behaviour:
  - int_pend sets on any cycle with i_int=1.
  - A request arriving in the same cycle that int_pend clears re-sets it (set wins).
  - Multiple requests while pending merge into one.
- Stall counter increments by 1 per cycle with o_pc_hold=1. It holds at all-ones.

## Timing
- During rst=1:
  - all four enables are 1;
  - flush_ifid, flush_idex and flush_memwb are 1;
  - EX/MEM is also bubbled upstream by the flushed ID/EX;
  - pc_hold=1, mem_half=0, int_inject=0.
- Next edge after rst=1: state=RUN, int_pend=0, stall_cnt=0.
- Reset asserted in WIDE2 aborts the access. The next cycle is RUN with mem_half=0.
- Wide access has a fixed latency of 2 cycles and adds exactly 1 stall cycle.
- Load-use adds 1 stall cycle. Branch costs 2 bubbles. Interrupt injection costs 1 cycle.
- i_int is sampled every edge, including when rst=0 and the pipeline is stalled. Injection occurs in the first RUN cycle with no higher-priority condition.
- Branch and load-use in the same cycle: branch wins and pc_hold=0.

## Test plan
- **Reset**: rst=1 for 2 cycles → all enables=1, the three flushes=1, pc_hold=1. After release: state RUN, o_stall_cnt=0, default outputs.
- **Load-use**:
  - i_ex_mem_read=1, i_ex_rdst=3, i_id_rsrc2=3, i_id_use2=1 → one cycle with en_ifid=0, pc_hold=1, flush_idex=1. Next cycle defaults; stall_cnt=1.
  - Repeat with i_id_use2=0 → no stall.
- **Wide access**: i_mem_wide=1 for 2 cycles → cycle 1: mem_half=0, en_exmem=0, flush_memwb=1. Cycle 2: mem_half=1, all enables=1. Cycle 3: RUN.
- **Wide and branch together**: i_mem_wide=1 with i_branch_taken=1 → no flush in cycle 1. Branch held high in cycle 2 → flush_ifid=flush_idex=1 in WIDE2.
- **Interrupt**:
  - i_int pulse during a load-use stall → injection one cycle after the stall (int_inject=1, pc_hold=1); int_pend clears.
  - Two i_int pulses before injection → exactly one inject.
- **Saturation**: with CNT_W=4, hold load-use for 20 cycles → o_stall_cnt stops at 15.
